// File: rtl/ltc_frame_decode.sv
// SMPTE LTC frame decoder: assembles 80-bit frames from the recovered bit stream, hunts for and
// tracks the sync word, validates the BCD fields and publishes timecode, user bits and flags.
module ltc_frame_decode #(
    parameter logic [15:0] SYNC_WORD     = 16'hBFFC,
    parameter int unsigned SYNC_MISS_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nosignal,
    input  logic        sda,
    input  logic        sck,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        sync_error,
    output logic        locked,
    output logic [5:0]  hours,
    output logic [6:0]  minutes,
    output logic [6:0]  seconds,
    output logic [5:0]  frames,
    output logic        drop_frame,
    output logic        color_frame,
    output logic [31:0] user_bits
);

    localparam int unsigned      MissW    = $clog2(SYNC_MISS_MAX + 1);
    localparam logic [MissW-1:0] MissLast = MissW'(SYNC_MISS_MAX - 1);

    typedef enum logic {StHunt, StLocked} state_e;

    state_e             state_q, state_d;
    logic [79:0]        sr_q, sr_d;
    logic [6:0]         bit_cnt_q, bit_cnt_d;
    logic [MissW-1:0]   miss_cnt_q, miss_cnt_d;
    logic               sck_q;
    logic               chk_q;

    logic               frame_valid_q, frame_valid_d;
    logic               frame_error_q, frame_error_d;
    logic               sync_error_q, sync_error_d;
    logic [5:0]         hours_q, hours_d;
    logic [6:0]         minutes_q, minutes_d;
    logic [6:0]         seconds_q, seconds_d;
    logic [5:0]         frames_q, frames_d;
    logic               drop_frame_q, drop_frame_d;
    logic               color_frame_q, color_frame_d;
    logic [31:0]        user_bits_q, user_bits_d;

    logic               bit_ev;
    logic               sync_hit;
    logic               bcd_ok;
    logic               frame_good;
    logic [3:0]         fr_u, sec_u, min_u, hr_u;
    logic [1:0]         fr_t, hr_t;
    logic [2:0]         sec_t, min_t;

    assign bit_ev   = sck & ~sck_q;
    assign sync_hit = (sr_q[79:64] == SYNC_WORD);

    assign fr_u  = sr_q[3:0];
    assign fr_t  = sr_q[9:8];
    assign sec_u = sr_q[19:16];
    assign sec_t = sr_q[26:24];
    assign min_u = sr_q[35:32];
    assign min_t = sr_q[42:40];
    assign hr_u  = sr_q[51:48];
    assign hr_t  = sr_q[57:56];

    // Hours are capped at 23, so a tens digit of 2 limits the units digit to 3.
    assign bcd_ok = (fr_u <= 4'd9) && (fr_t <= 2'd2) &&
                    (sec_u <= 4'd9) && (sec_t <= 3'd5) &&
                    (min_u <= 4'd9) && (min_t <= 3'd5) &&
                    (hr_u <= 4'd9) && (hr_t <= 2'd2) &&
                    !((hr_t == 2'd2) && (hr_u > 4'd3));

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        sync_error_d  = 1'b0;
        hours_d       = hours_q;
        minutes_d     = minutes_q;
        seconds_d     = seconds_q;
        frames_d      = frames_q;
        drop_frame_d  = drop_frame_q;
        color_frame_d = color_frame_q;
        user_bits_d   = user_bits_q;
        frame_good    = 1'b0;

        if (nosignal) begin
            state_d    = StHunt;
            sr_d       = '0;
            bit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (bit_ev) begin
                sr_d = {sda, sr_q[79:1]};
                if (state_q == StLocked) begin
                    bit_cnt_d = (bit_cnt_q == 7'd79) ? 7'd0 : bit_cnt_q + 7'd1;
                end
            end

            // chk_q and bit_ev are never high together: a bit event needs sck low last cycle.
            if (chk_q) begin
                case (state_q)
                    StHunt: begin
                        if (sync_hit) begin
                            state_d    = StLocked;
                            bit_cnt_d  = '0;
                            miss_cnt_d = '0;
                            frame_good = 1'b1;
                        end
                    end
                    StLocked: begin
                        if (bit_cnt_q == 7'd0) begin
                            if (sync_hit) begin
                                miss_cnt_d = '0;
                                frame_good = 1'b1;
                            end else begin
                                sync_error_d = 1'b1;
                                if (miss_cnt_q == MissLast) begin
                                    state_d    = StHunt;
                                    miss_cnt_d = '0;
                                end else begin
                                    miss_cnt_d = miss_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (frame_good) begin
                if (bcd_ok) begin
                    frame_valid_d = 1'b1;
                    hours_d       = {hr_t, hr_u};
                    minutes_d     = {min_t, min_u};
                    seconds_d     = {sec_t, sec_u};
                    frames_d      = {fr_t, fr_u};
                    drop_frame_d  = sr_q[10];
                    color_frame_d = sr_q[11];
                    user_bits_d   = {sr_q[63:60], sr_q[55:52], sr_q[47:44], sr_q[39:36],
                                     sr_q[31:28], sr_q[23:20], sr_q[15:12], sr_q[7:4]};
                end else begin
                    frame_error_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHunt;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            sck_q         <= 1'b0;
            chk_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            sync_error_q  <= 1'b0;
            hours_q       <= '0;
            minutes_q     <= '0;
            seconds_q     <= '0;
            frames_q      <= '0;
            drop_frame_q  <= 1'b0;
            color_frame_q <= 1'b0;
            user_bits_q   <= '0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            sck_q         <= sck;
            chk_q         <= bit_ev & ~nosignal;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            sync_error_q  <= sync_error_d;
            hours_q       <= hours_d;
            minutes_q     <= minutes_d;
            seconds_q     <= seconds_d;
            frames_q      <= frames_d;
            drop_frame_q  <= drop_frame_d;
            color_frame_q <= color_frame_d;
            user_bits_q   <= user_bits_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign sync_error  = sync_error_q;
    assign locked      = (state_q == StLocked);
    assign hours       = hours_q;
    assign minutes     = minutes_q;
    assign seconds     = seconds_q;
    assign frames      = frames_q;
    assign drop_frame  = drop_frame_q;
    assign color_frame = color_frame_q;
    assign user_bits   = user_bits_q;

endmodule
